// File: rtl/nn_weight_loader.sv
// Weight RAM writer: packs a byte stream (little-endian) into WORD_W-bit words
// and writes them to consecutive RAM addresses starting at 0.
module nn_weight_loader #(
    parameter int WORD_W    = 256,
    parameter int BYTE_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int NUM_WORDS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
);

    localparam int BYTES = WORD_W / BYTE_W;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t            state;
    logic [BC_W-1:0]   byte_cnt;
    logic [ADDR_W-1:0] word_cnt;
    logic [WORD_W-1:0] pack;
    logic [WORD_W-1:0] pack_next;
    logic              accept;

    assign in_ready = (state == FILL);
    assign accept   = in_ready && in_valid;

    // The final byte of a word goes straight into mem_wdata so the write
    // happens in the cycle right after the last accept.
    always_comb begin
        pack_next = pack;
        pack_next[int'(byte_cnt) * BYTE_W +: BYTE_W] = in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            word_cnt      <= '0;
            pack          <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= FILL;
                        byte_cnt      <= '0;
                        word_cnt      <= '0;
                        words_written <= '0;
                        busy          <= 1'b1;
                    end
                end
                FILL: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (accept) begin
                        pack <= pack_next;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt  <= '0;
                            state     <= WRITE;
                            mem_we    <= 1'b1;
                            mem_addr  <= word_cnt;
                            mem_wdata <= pack_next;
                        end else begin
                            byte_cnt <= byte_cnt + BC_W'(1);
                        end
                    end
                end
                WRITE: begin
                    // The write in this cycle always commits, even on abort.
                    words_written <= words_written + (ADDR_W + 1)'(1);
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (word_cnt == LAST_WORD) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        word_cnt <= word_cnt + ADDR_W'(1);
                        state    <= FILL;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_weight_loader.sv
// Directed bench for nn_weight_loader: table of load scenarios on a 16-word
// instance plus hand sequences (single word on a 1-word instance, reset, abort).
module tb_nn_weight_loader;

    localparam int WORD_W = 256;
    localparam int BYTE_W = 8;
    localparam int ADDR_W = 4;
    localparam int NW     = 16;

    logic              clk = 1'b0;
    logic              reset, start, abort, in_valid;
    logic [BYTE_W-1:0] in_data;

    logic              in_ready, mem_we, busy, done;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [ADDR_W:0]   words_written;

    logic              in_ready1, mem_we1, busy1, done1;
    logic [ADDR_W-1:0] mem_addr1;
    logic [WORD_W-1:0] mem_wdata1;
    logic [ADDR_W:0]   words_written1;

    always #5 clk = ~clk;

    nn_weight_loader #(.WORD_W(WORD_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W), .NUM_WORDS(NW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .busy(busy), .done(done), .words_written(words_written)
    );

    nn_weight_loader #(.WORD_W(WORD_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W), .NUM_WORDS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1),
        .busy(busy1), .done(done1), .words_written(words_written1)
    );

    typedef struct {
        int nbytes;
        bit gaps;
        bit do_abort;
        int exp_wr;
        int exp_ww;
        int exp_done;
    } load_t;

    int total = 0, bad = 0;
    int cyc = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    function automatic logic [255:0] exp_word(input int n);
        logic [255:0] w;
        for (int j = 0; j < 32; j++) w[j*8 +: 8] = 8'(32 * n + j);
        return w;
    endfunction

    // RAM-side scoreboard for the 16-word instance: stream byte k is k[7:0].
    always @(negedge clk) begin
        cyc++;
        if (mem_we) begin
            chk("wr_addr", 256'(mem_addr), 256'(wr_cnt));
            chk("wr_data", mem_wdata, exp_word(wr_cnt));
            chk("ready_in_write", 256'(in_ready), 256'(0));
            wr_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        wr_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    // Presents bytes first..first+n-1; returns #1 after the edge accepting the last one.
    task automatic feed(input int n, input bit gaps, input int first);
        bit acc;
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                for (int g = 0; g < 6 && $urandom_range(0, 1) == 1; g++) begin
                    in_valid = 1'b0;
                    tick();
                end
            end
            in_valid = 1'b1;
            in_data  = 8'(first + k);
            acc = 1'b0;
            for (int t = 0; t < 60 && !acc; t++) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                fail_now("feed_accept");
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_load(input load_t v);
        clear_counts();
        pulse_start();
        feed(v.nbytes, v.gaps, 0);
        if (v.do_abort) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            @(negedge clk);
            chk("abort_busy", 256'(busy), 256'(0));
            chk("abort_ready", 256'(in_ready), 256'(0));
        end else begin
            for (int i = 0; i < 100 && done_cnt == 0; i++) @(negedge clk);
            if (done_cnt == 0) fail_now("done_wait");
            else if (!v.gaps) chk("load_cycles", 256'(done_cyc - start_cyc), 256'(NW * 33 + 2));
        end
        repeat (4) @(negedge clk);
        chk("writes", 256'(wr_cnt), 256'(v.exp_wr));
        chk("done_pulses", 256'(done_cnt), 256'(v.exp_done));
        chk("words_written", 256'(words_written), 256'(v.exp_ww));
        tick();
    endtask

    load_t tbl[5];

    initial begin
        tbl[0] = '{nbytes: 512, gaps: 1'b0, do_abort: 1'b0, exp_wr: 16, exp_ww: 16, exp_done: 1};
        tbl[1] = '{nbytes: 42,  gaps: 1'b0, do_abort: 1'b1, exp_wr: 1,  exp_ww: 1,  exp_done: 0};
        tbl[2] = '{nbytes: 512, gaps: 1'b1, do_abort: 1'b0, exp_wr: 16, exp_ww: 16, exp_done: 1};
        tbl[3] = '{nbytes: 64,  gaps: 1'b1, do_abort: 1'b1, exp_wr: 2,  exp_ww: 2,  exp_done: 0};
        tbl[4] = '{nbytes: 5,   gaps: 1'b0, do_abort: 1'b1, exp_wr: 0,  exp_ww: 0,  exp_done: 0};

        do_reset();
        @(negedge clk);
        chk("rst_we", 256'(mem_we), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_ready", 256'(in_ready), 256'(0));
        chk("rst_addr", 256'(mem_addr), 256'(0));
        chk("rst_wdata", mem_wdata, 256'(0));
        chk("rst_ww", 256'(words_written), 256'(0));
        chk("rst_done1", 256'(done1), 256'(0));
        tick();

        // Single word on the 1-word instance.
        pulse_start();
        feed(32, 1'b0, 0);
        @(negedge clk);
        chk("sw_we", 256'(mem_we1), 256'(1));
        chk("sw_addr", 256'(mem_addr1), 256'(0));
        chk("sw_data", mem_wdata1,
            256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);
        chk("sw_done_early", 256'(done1), 256'(0));
        @(negedge clk);
        chk("sw_done", 256'(done1), 256'(1));
        chk("sw_we_off", 256'(mem_we1), 256'(0));
        chk("sw_ww", 256'(words_written1), 256'(1));
        @(negedge clk);
        chk("sw_done_once", 256'(done1), 256'(0));
        tick();
        do_reset();

        // start while busy is ignored, then reset lands on the WRITE cycle.
        clear_counts();
        pulse_start();
        feed(10, 1'b0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("midstart_busy", 256'(busy), 256'(1));
        chk("midstart_ready", 256'(in_ready), 256'(1));
        tick();
        feed(22, 1'b0, 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rstw_we", 256'(mem_we), 256'(0));
        chk("rstw_busy", 256'(busy), 256'(0));
        chk("rstw_ready", 256'(in_ready), 256'(0));
        chk("rstw_writes", 256'(wr_cnt), 256'(1));
        tick();

        // abort coinciding with the WRITE cycle.
        clear_counts();
        pulse_start();
        feed(32, 1'b0, 0);
        abort = 1'b1;
        @(negedge clk);
        chk("abw_we", 256'(mem_we), 256'(1));
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abw_busy", 256'(busy), 256'(0));
        chk("abw_ready", 256'(in_ready), 256'(0));
        chk("abw_ww", 256'(words_written), 256'(1));
        chk("abw_we_off", 256'(mem_we), 256'(0));
        repeat (3) @(negedge clk);
        chk("abw_no_done", 256'(done_cnt), 256'(0));
        tick();

        for (int i = 0; i < 5; i++) run_load(tbl[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nn_weight_loader.md
Name: nn_weight_loader

Overview:
Writer side of the feed-forward NN weight RAM. Accepts a byte stream over a valid/ready handshake and packs each group of 32 bytes into a 256-bit word. Writes the words into consecutive weight RAM addresses (RAM port: address, write data, write enable). The NN datapath then reads the weights back from those addresses.

Parameters:
WORD_W, 256, RAM word width in bits; must be a multiple of BYTE_W
BYTE_W, 8, input stream width in bits
ADDR_W, 4, RAM address width
NUM_WORDS, 16, words per load; range 1..2^ADDR_W

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high
start  input  1  begin a load; sampled only in IDLE
abort  input  1  cancel the current load; returns to IDLE
in_data  input  BYTE_W  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a byte
mem_addr  output  ADDR_W  RAM write address
mem_wdata  output  WORD_W  RAM write data
mem_we  output  1  RAM write enable, one-cycle pulse per word
busy  output  1  high in FILL and WRITE
done  output  1  one-cycle pulse when a load completes
words_written  output  ADDR_W+1  words committed in current/last load

Behaviour:
- Clock, reset: reset reset, synchronous, active-high; clock clk.
- Reset values: all outputs 0, state=IDLE; byte_cnt, word_cnt and the pack register cleared.
- All outputs are registered, except in_ready, which is decoded from state (state==FILL).
- States:
  - IDLE: if start, go to FILL, clear byte_cnt/word_cnt, words_written=0. Otherwise stay.
  - FILL: in_ready=1. When in_valid and in_ready, the byte is accepted and written into pack[byte_cnt*BYTE_W +: BYTE_W]. The first byte lands in bits [7:0] (little-endian). byte_cnt increments. On the accept that makes byte_cnt reach WORD_W/BYTE_W (32), go to WRITE and wrap byte_cnt to 0.
  - WRITE: exactly one cycle. mem_we=1, mem_addr=word_cnt, mem_wdata=pack, in_ready=0. Next cycle words_written increments. If word_cnt==NUM_WORDS-1, go to DONE; else increment word_cnt and return to FILL.
  - DONE: done=1 for one cycle, then go to IDLE.
- mem_we is 0 in every state except WRITE. mem_addr and mem_wdata hold their last values when mem_we=0.
- Latency: mem_we is asserted in the cycle immediately after the 32nd byte of a word is accepted. Minimum time per word is 33 cycles (32 accepts plus 1 write). Minimum time for a full load is NUM_WORDS*33 + 1 (DONE) + 1 (IDLE→FILL) cycles.
- Backpressure: in_valid low in FILL stalls without state change. A byte presented while in_ready=0 (IDLE, WRITE, DONE) is not consumed; the upstream source must hold it.
- abort: in FILL or WRITE, next state is IDLE, no done pulse, and a partial word is never written. If abort and a WRITE cycle coincide, the write completes (mem_we=1 that cycle) and then the block goes to IDLE. words_written keeps the count of committed words. abort in IDLE or DONE has no effect (DONE still pulses).
- start while busy is ignored.
- start in the same cycle as the DONE pulse is ignored. start in IDLE the cycle after DONE begins a new load.
- Reset mid-load: immediate return to reset values. The RAM is not cleared.
- The address never exceeds NUM_WORDS-1, so there is no wrap-around within a load. Each new load starts again at address 0.

Test Plan:
- Single word (NUM_WORDS=1): start, then bytes 0x00..0x1F back-to-back → mem_we for 1 cycle, 1 cycle after the last accept, with mem_addr=0 and mem_wdata=0x1F1E...0100. done pulses the next cycle; words_written=1.
- Full load (NUM_WORDS=16): 512 bytes where byte k = k[7:0] → 16 writes at addresses 0..15, word n bytes = 32n..32n+31. done pulses once; total cycles = 16*33+2. A RAM read-back model matches every address.
- Backpressure: in_valid toggled randomly 50% over a 2-word load → same mem_wdata as the back-to-back case. in_ready=0 during WRITE; no byte lost or duplicated.
- Abort after 10 bytes of word 1 → no mem_we for word 1, no done pulse, busy=0 next cycle, words_written=1. A following start reloads from address 0.
- Reset asserted during WRITE → mem_we=0, busy=0, in_ready=0 next cycle. start ignored while busy: asserting start mid-load changes nothing.
- Simultaneous abort and WRITE → mem_we=1 that cycle, then IDLE; words_written incremented; done stays 0.
